// File: rtl/axi_lite_reg_responder.sv
// AXI4-Lite register block: ID, SCRATCH, GPIO_OUT, GPIO_IN and an optional free-running CYCLE counter.
// Define AXI_LITE_REG_RESPONDER_CYCLE_EN to build the CYCLE counter at offset 0x10.
module axi_lite_reg_responder #(
    parameter int          ADDR_WIDTH = 16,
    parameter logic [31:0] ID_VALUE   = 32'h56455230
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    input  logic [15:0]           gpio_i,
    output logic [15:0]           gpio_o,
    output logic [1:0]            o_dbg_wr_state,
    output logic                  o_dbg_rd_state
);

    // Handshake rule on every channel: a beat transfers on the rising edge where
    // valid and ready are both 1; a source holds valid and payload until then.

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] IDX_ID       = 3'd0;
    localparam logic [2:0] IDX_SCRATCH  = 3'd1;
    localparam logic [2:0] IDX_GPIO_OUT = 3'd2;
    localparam logic [2:0] IDX_GPIO_IN  = 3'd3;
`ifdef AXI_LITE_REG_RESPONDER_CYCLE_EN
    localparam logic [2:0] IDX_CYCLE    = 3'd4;
`endif

    typedef enum logic [1:0] {
        WR_IDLE   = 2'd0,
        WR_WAIT_W = 2'd1,
        WR_WAIT_A = 2'd2,
        WR_RESP   = 2'd3
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_t;

    wr_state_t   r_wr_state;
    wr_state_t   w_wr_next;
    rd_state_t   r_rd_state;
    rd_state_t   w_rd_next;

    logic [2:0]  r_aw_idx;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [1:0]  r_bresp;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;

    logic [31:0] r_scratch;
    logic [15:0] r_gpio_out;
    logic [15:0] r_gpio_s1;
    logic [15:0] r_gpio_s2;

    logic        w_awready;
    logic        w_wready;
    logic        w_commit;
    logic        w_lat_addr;
    logic        w_lat_data;
    logic [2:0]  w_wr_idx;
    logic [31:0] w_wr_data;
    logic [3:0]  w_wr_strb;
    logic        w_wr_ok;

    logic        w_ar_capture;
    logic [31:0] w_rd_data;
    logic [1:0]  w_rd_resp;

    // Protection bits and address bits outside [4:2] carry no meaning here.
    logic        w_unused;
    assign w_unused = ^{s_axi_awprot, s_axi_arprot,
                        s_axi_awaddr[ADDR_WIDTH-1:5], s_axi_awaddr[1:0],
                        s_axi_araddr[ADDR_WIDTH-1:5], s_axi_araddr[1:0]};

    // ---------------- write channel ----------------
    always_comb begin
        w_wr_next  = r_wr_state;
        w_awready  = 1'b0;
        w_wready   = 1'b0;
        w_commit   = 1'b0;
        w_lat_addr = 1'b0;
        w_lat_data = 1'b0;
        w_wr_idx   = s_axi_awaddr[4:2];
        w_wr_data  = s_axi_wdata;
        w_wr_strb  = s_axi_wstrb;
        case (r_wr_state)
            WR_IDLE: begin
                w_awready = 1'b1;
                w_wready  = 1'b1;
                if (s_axi_awvalid && s_axi_wvalid) begin
                    w_commit  = 1'b1;
                    w_wr_next = WR_RESP;
                end else if (s_axi_awvalid) begin
                    w_lat_addr = 1'b1;
                    w_wr_next  = WR_WAIT_W;
                end else if (s_axi_wvalid) begin
                    w_lat_data = 1'b1;
                    w_wr_next  = WR_WAIT_A;
                end
            end
            WR_WAIT_W: begin
                w_wready = 1'b1;
                w_wr_idx = r_aw_idx;
                if (s_axi_wvalid) begin
                    w_commit  = 1'b1;
                    w_wr_next = WR_RESP;
                end
            end
            WR_WAIT_A: begin
                w_awready = 1'b1;
                w_wr_data = r_wdata;
                w_wr_strb = r_wstrb;
                if (s_axi_awvalid) begin
                    w_commit  = 1'b1;
                    w_wr_next = WR_RESP;
                end
            end
            WR_RESP: begin
                if (s_axi_bready) begin
                    w_wr_next = WR_IDLE;
                end
            end
            default: w_wr_next = WR_IDLE;
        endcase
    end

    assign w_wr_ok = (w_wr_idx == IDX_SCRATCH) || (w_wr_idx == IDX_GPIO_OUT);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_state <= WR_IDLE;
            r_aw_idx   <= 3'd0;
            r_wdata    <= 32'd0;
            r_wstrb    <= 4'd0;
            r_bresp    <= RESP_OKAY;
            r_scratch  <= 32'd0;
            r_gpio_out <= 16'd0;
        end else begin
            r_wr_state <= w_wr_next;
            if (w_lat_addr) begin
                r_aw_idx <= s_axi_awaddr[4:2];
            end
            if (w_lat_data) begin
                r_wdata <= s_axi_wdata;
                r_wstrb <= s_axi_wstrb;
            end
            if (w_commit) begin
                r_bresp <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
                for (int b = 0; b < 4; b++) begin
                    if (w_wr_strb[b] && (w_wr_idx == IDX_SCRATCH)) begin
                        r_scratch[b*8 +: 8] <= w_wr_data[b*8 +: 8];
                    end
                end
                for (int b = 0; b < 2; b++) begin
                    if (w_wr_strb[b] && (w_wr_idx == IDX_GPIO_OUT)) begin
                        r_gpio_out[b*8 +: 8] <= w_wr_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Ready is forced low while reset is applied so nothing is accepted then.
    assign s_axi_awready = w_awready & resetn;
    assign s_axi_wready  = w_wready & resetn;
    assign s_axi_bvalid  = (r_wr_state == WR_RESP);
    assign s_axi_bresp   = r_bresp;
    assign gpio_o        = r_gpio_out;

    // ---------------- GPIO input synchronizer ----------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_gpio_s1 <= 16'd0;
            r_gpio_s2 <= 16'd0;
        end else begin
            r_gpio_s1 <= gpio_i;
            r_gpio_s2 <= r_gpio_s1;
        end
    end

    // ---------------- optional cycle counter ----------------
`ifdef AXI_LITE_REG_RESPONDER_CYCLE_EN
    logic [31:0] r_cycle;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cycle <= 32'd0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end
`endif

    // ---------------- read channel ----------------
    // The mux sees register values from before this edge, so a read racing a
    // write to the same register returns the old contents.
    always_comb begin
        w_rd_data = 32'd0;
        w_rd_resp = RESP_OKAY;
        case (s_axi_araddr[4:2])
            IDX_ID:       w_rd_data = ID_VALUE;
            IDX_SCRATCH:  w_rd_data = r_scratch;
            IDX_GPIO_OUT: w_rd_data = {16'd0, r_gpio_out};
            IDX_GPIO_IN:  w_rd_data = {16'd0, r_gpio_s2};
`ifdef AXI_LITE_REG_RESPONDER_CYCLE_EN
            IDX_CYCLE:    w_rd_data = r_cycle;
`endif
            default: begin
                w_rd_data = 32'd0;
                w_rd_resp = RESP_SLVERR;
            end
        endcase
    end

    always_comb begin
        w_rd_next    = r_rd_state;
        w_ar_capture = 1'b0;
        case (r_rd_state)
            RD_IDLE: begin
                if (s_axi_arvalid) begin
                    w_ar_capture = 1'b1;
                    w_rd_next    = RD_DATA;
                end
            end
            RD_DATA: begin
                if (s_axi_rready) begin
                    w_rd_next = RD_IDLE;
                end
            end
            default: w_rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rd_state <= RD_IDLE;
            r_rdata    <= 32'd0;
            r_rresp    <= RESP_OKAY;
        end else begin
            r_rd_state <= w_rd_next;
            if (w_ar_capture) begin
                r_rdata <= w_rd_data;
                r_rresp <= w_rd_resp;
            end
        end
    end

    assign s_axi_arready  = (r_rd_state == RD_IDLE) & resetn;
    assign s_axi_rvalid   = (r_rd_state == RD_DATA);
    assign s_axi_rdata    = r_rdata;
    assign s_axi_rresp    = r_rresp;

    assign o_dbg_wr_state = r_wr_state;
    assign o_dbg_rd_state = r_rd_state;

endmodule

// File: tb/tb_axi_lite_reg_responder.sv
// Directed self-checking bench for axi_lite_reg_responder; inputs change 1 time unit after
// each rising edge and outputs are compared at that same point, away from the edge.
module tb_axi_lite_reg_responder;

    logic        clk;
    logic        resetn;
    logic [15:0] s_axi_awaddr;
    logic [2:0]  s_axi_awprot;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [15:0] s_axi_araddr;
    logic [2:0]  s_axi_arprot;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [15:0] gpio_i;
    logic [15:0] gpio_o;
    logic [1:0]  o_dbg_wr_state;
    logic        o_dbg_rd_state;

    int          checks;
    int          errors;
    logic [1:0]  last_bresp;
    logic [31:0] last_rdata;
    logic [1:0]  last_rresp;

    localparam logic [31:0] ID_EXP = 32'h56455230;

    axi_lite_reg_responder dut (
        .clk            (clk),
        .resetn         (resetn),
        .s_axi_awaddr   (s_axi_awaddr),
        .s_axi_awprot   (s_axi_awprot),
        .s_axi_awvalid  (s_axi_awvalid),
        .s_axi_awready  (s_axi_awready),
        .s_axi_wdata    (s_axi_wdata),
        .s_axi_wstrb    (s_axi_wstrb),
        .s_axi_wvalid   (s_axi_wvalid),
        .s_axi_wready   (s_axi_wready),
        .s_axi_bresp    (s_axi_bresp),
        .s_axi_bvalid   (s_axi_bvalid),
        .s_axi_bready   (s_axi_bready),
        .s_axi_araddr   (s_axi_araddr),
        .s_axi_arprot   (s_axi_arprot),
        .s_axi_arvalid  (s_axi_arvalid),
        .s_axi_arready  (s_axi_arready),
        .s_axi_rdata    (s_axi_rdata),
        .s_axi_rresp    (s_axi_rresp),
        .s_axi_rvalid   (s_axi_rvalid),
        .s_axi_rready   (s_axi_rready),
        .gpio_i         (gpio_i),
        .gpio_o         (gpio_o),
        .o_dbg_wr_state (o_dbg_wr_state),
        .o_dbg_rd_state (o_dbg_rd_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired before the summary");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        s_axi_awaddr  = addr;
        s_axi_wdata   = data;
        s_axi_wstrb   = strb;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        n = 0;
        while (!s_axi_bvalid && n < 8) begin
            tick();
            n++;
        end
        chk("wr_bvalid_seen", {31'd0, s_axi_bvalid}, 32'd1);
        last_bresp   = s_axi_bresp;
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
    endtask

    task automatic rd(input logic [15:0] addr);
        int n;
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        n = 0;
        while (!s_axi_rvalid && n < 8) begin
            tick();
            n++;
        end
        chk("rd_rvalid_seen", {31'd0, s_axi_rvalid}, 32'd1);
        last_rdata   = s_axi_rdata;
        last_rresp   = s_axi_rresp;
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        checks        = 0;
        errors        = 0;
        resetn        = 1'b0;
        s_axi_awaddr  = 16'd0;
        s_axi_awprot  = 3'd0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = 32'd0;
        s_axi_wstrb   = 4'd0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b0;
        s_axi_araddr  = 16'd0;
        s_axi_arprot  = 3'd0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        gpio_i        = 16'd0;
        last_bresp    = 2'd0;
        last_rdata    = 32'd0;
        last_rresp    = 2'd0;

        // Reset state
        tick();
        tick();
        chk("rst_awready", {31'd0, s_axi_awready}, 32'd0);
        chk("rst_wready",  {31'd0, s_axi_wready},  32'd0);
        chk("rst_arready", {31'd0, s_axi_arready}, 32'd0);
        chk("rst_bvalid",  {31'd0, s_axi_bvalid},  32'd0);
        chk("rst_rvalid",  {31'd0, s_axi_rvalid},  32'd0);
        chk("rst_rdata",   s_axi_rdata,            32'd0);
        chk("rst_gpio_o",  {16'd0, gpio_o},        32'd0);
        resetn = 1'b1;
        #1;
        chk("post_rst_awready", {31'd0, s_axi_awready}, 32'd1);
        chk("post_rst_wready",  {31'd0, s_axi_wready},  32'd1);
        chk("post_rst_arready", {31'd0, s_axi_arready}, 32'd1);
        tick();

        // Simultaneous AW+W to SCRATCH, response the next cycle
        s_axi_awaddr  = 16'h0004;
        s_axi_wdata   = 32'hDEADBEEF;
        s_axi_wstrb   = 4'hF;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        chk("t1_bvalid",  {31'd0, s_axi_bvalid},  32'd1);
        chk("t1_bresp",   {30'd0, s_axi_bresp},   32'd0);
        chk("t1_awready", {31'd0, s_axi_awready}, 32'd0);
        chk("t1_wready",  {31'd0, s_axi_wready},  32'd0);
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        chk("t1_bvalid_drop",  {31'd0, s_axi_bvalid},  32'd0);
        chk("t1_awready_back", {31'd0, s_axi_awready}, 32'd1);
        s_axi_araddr  = 16'h0004;
        s_axi_arvalid = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        chk("t1_rvalid",  {31'd0, s_axi_rvalid},  32'd1);
        chk("t1_rdata",   s_axi_rdata,            32'hDEADBEEF);
        chk("t1_rresp",   {30'd0, s_axi_rresp},   32'd0);
        chk("t1_arready", {31'd0, s_axi_arready}, 32'd0);
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        chk("t1_rvalid_drop", {31'd0, s_axi_rvalid}, 32'd0);

        // W three cycles ahead of AW to GPIO_OUT, low byte only
        s_axi_wdata  = 32'h0000A5A5;
        s_axi_wstrb  = 4'h1;
        s_axi_wvalid = 1'b1;
        tick();
        s_axi_wvalid = 1'b0;
        chk("t2_wait_a_awready", {31'd0, s_axi_awready}, 32'd1);
        chk("t2_wait_a_wready",  {31'd0, s_axi_wready},  32'd0);
        chk("t2_wait_a_bvalid",  {31'd0, s_axi_bvalid},  32'd0);
        tick();
        tick();
        s_axi_awaddr  = 16'h0008;
        s_axi_awvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        chk("t2_bvalid", {31'd0, s_axi_bvalid}, 32'd1);
        chk("t2_bresp",  {30'd0, s_axi_bresp},  32'd0);
        chk("t2_gpio_o", {16'd0, gpio_o},       32'h000000A5);
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        wr(16'h0008, 32'hFFFF7700, 4'h2);
        chk("t2_lane1_bresp", {30'd0, last_bresp}, 32'd0);
        chk("t2_lane1_gpio_o", {16'd0, gpio_o}, 32'h000077A5);
        rd(16'h0008);
        chk("t2_gpio_out_rd", last_rdata, 32'h000077A5);

        // Byte strobes and the empty-strobe write on SCRATCH; address aliasing
        wr(16'h0004, 32'h11223344, 4'h5);
        chk("t3_strb5_bresp", {30'd0, last_bresp}, 32'd0);
        rd(16'h0004);
        chk("t3_strb5_data", last_rdata, 32'hDE22BE44);
        wr(16'h0004, 32'hFFFFFFFF, 4'h0);
        chk("t3_strb0_bresp", {30'd0, last_bresp}, 32'd0);
        rd(16'h0004);
        chk("t3_strb0_data", last_rdata, 32'hDE22BE44);
        rd(16'h0024);
        chk("t3_alias_data", last_rdata, 32'hDE22BE44);
        chk("t3_alias_rresp", {30'd0, last_rresp}, 32'd0);

        // Read-only and unmapped offsets
        wr(16'h0000, 32'h12345678, 4'hF);
        chk("t4_wr_id_bresp", {30'd0, last_bresp}, 32'd2);
        wr(16'h000C, 32'h0000FFFF, 4'hF);
        chk("t4_wr_gpin_bresp", {30'd0, last_bresp}, 32'd2);
        wr(16'h001C, 32'h0000FFFF, 4'hF);
        chk("t4_wr_1c_bresp", {30'd0, last_bresp}, 32'd2);
        rd(16'h0018);
        chk("t4_rd_18_data", last_rdata, 32'd0);
        chk("t4_rd_18_rresp", {30'd0, last_rresp}, 32'd2);
        rd(16'h0000);
        chk("t4_rd_id_data", last_rdata, ID_EXP);
        chk("t4_rd_id_rresp", {30'd0, last_rresp}, 32'd0);
        rd(16'h0004);
        chk("t4_scratch_kept", last_rdata, 32'hDE22BE44);
        rd(16'h000C);
        chk("t4_gpin_kept", last_rdata, 32'd0);
`ifndef AXI_LITE_REG_RESPONDER_CYCLE_EN
        rd(16'h0010);
        chk("t4_rd_10_data", last_rdata, 32'd0);
        chk("t4_rd_10_rresp", {30'd0, last_rresp}, 32'd2);
`endif
        wr(16'h0010, 32'h00000001, 4'hF);
        chk("t4_wr_10_bresp", {30'd0, last_bresp}, 32'd2);

        // Back-pressure on both responses; the read races a write to SCRATCH
        s_axi_awaddr  = 16'h0004;
        s_axi_wdata   = 32'hCAFEF00D;
        s_axi_wstrb   = 4'hF;
        s_axi_araddr  = 16'h0004;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        s_axi_arvalid = 1'b1;
        tick();
        s_axi_awaddr = 16'h0008;
        s_axi_wdata  = 32'h00000000;
        s_axi_araddr = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_bvalid",  {31'd0, s_axi_bvalid},  32'd1);
            chk("t5_hold_bresp",   {30'd0, s_axi_bresp},   32'd0);
            chk("t5_hold_rvalid",  {31'd0, s_axi_rvalid},  32'd1);
            chk("t5_hold_rdata",   s_axi_rdata,            32'hDE22BE44);
            chk("t5_hold_rresp",   {30'd0, s_axi_rresp},   32'd0);
            chk("t5_hold_awready", {31'd0, s_axi_awready}, 32'd0);
            chk("t5_hold_wready",  {31'd0, s_axi_wready},  32'd0);
            chk("t5_hold_arready", {31'd0, s_axi_arready}, 32'd0);
            tick();
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_arvalid = 1'b0;
        s_axi_bready  = 1'b1;
        s_axi_rready  = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        s_axi_rready = 1'b0;
        chk("t5_bvalid_drop", {31'd0, s_axi_bvalid}, 32'd0);
        chk("t5_rvalid_drop", {31'd0, s_axi_rvalid}, 32'd0);
        rd(16'h0004);
        chk("t5_scratch_new", last_rdata, 32'hCAFEF00D);
        rd(16'h0008);
        chk("t5_gpio_out_kept", last_rdata, 32'h000077A5);

        // GPIO input through the two-flop synchronizer
        gpio_i        = 16'h1234;
        s_axi_araddr  = 16'h000C;
        s_axi_arvalid = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        chk("t6_gpin_edge1", s_axi_rdata, 32'd0);
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        rd(16'h000C);
        chk("t6_gpin_edge3", last_rdata, 32'h00001234);
        gpio_i = 16'h00F0;
        tick();
        s_axi_araddr  = 16'h000C;
        s_axi_arvalid = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        chk("t6_gpin_edge2_old", s_axi_rdata, 32'h00001234);
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        rd(16'h000C);
        chk("t6_gpin_new", last_rdata, 32'h000000F0);

        // Reset in the middle of a write that has only its address
        s_axi_awaddr  = 16'h0004;
        s_axi_awvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        chk("t7_wait_w_wready",  {31'd0, s_axi_wready},  32'd1);
        chk("t7_wait_w_awready", {31'd0, s_axi_awready}, 32'd0);
        resetn = 1'b0;
        tick();
        chk("t7_rst_bvalid",  {31'd0, s_axi_bvalid},  32'd0);
        chk("t7_rst_bresp",   {30'd0, s_axi_bresp},   32'd0);
        chk("t7_rst_awready", {31'd0, s_axi_awready}, 32'd0);
        chk("t7_rst_wready",  {31'd0, s_axi_wready},  32'd0);
        chk("t7_rst_arready", {31'd0, s_axi_arready}, 32'd0);
        chk("t7_rst_rvalid",  {31'd0, s_axi_rvalid},  32'd0);
        chk("t7_rst_rdata",   s_axi_rdata,            32'd0);
        chk("t7_rst_rresp",   {30'd0, s_axi_rresp},   32'd0);
        chk("t7_rst_gpio_o",  {16'd0, gpio_o},        32'd0);
        resetn = 1'b1;
        #1;
        chk("t7_rel_awready", {31'd0, s_axi_awready}, 32'd1);
        chk("t7_rel_wready",  {31'd0, s_axi_wready},  32'd1);
        chk("t7_rel_arready", {31'd0, s_axi_arready}, 32'd1);
        tick();
        rd(16'h0004);
        chk("t7_scratch_cleared", last_rdata, 32'd0);
        s_axi_wdata  = 32'h00000055;
        s_axi_wstrb  = 4'hF;
        s_axi_wvalid = 1'b1;
        tick();
        s_axi_wvalid = 1'b0;
        chk("t7_no_stale_bvalid", {31'd0, s_axi_bvalid}, 32'd0);
        s_axi_awaddr  = 16'h0004;
        s_axi_awvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        chk("t7_new_bvalid", {31'd0, s_axi_bvalid}, 32'd1);
        chk("t7_new_bresp",  {30'd0, s_axi_bresp},  32'd0);
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        rd(16'h0004);
        chk("t7_new_data", last_rdata, 32'h00000055);

`ifdef AXI_LITE_REG_RESPONDER_CYCLE_EN
        begin
            logic [31:0] c_first;
            rd(16'h0010);
            chk("t8_cycle_rresp", {30'd0, last_rresp}, 32'd0);
            c_first = last_rdata;
            for (int i = 0; i < 5; i++) tick();
            // AR edges are 2 (rd) + 5 (idle) = 7 cycles apart.
            rd(16'h0010);
            chk("t8_cycle_delta", last_rdata - c_first, 32'd7);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
